instr_word_loader: RTL and testbench

INSTR_WORD_LOADER -- requirements
Module: instr_word_loader

---
 rtl/instr_word_loader.sv | 169 ++++++++++++++++
 tb/tb_instr_word_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_word_loader.sv
// Instruction word loader: accepts decoded instruction field tuples over a
// valid/ready handshake, packs each into a 32-bit R- or I-type word and
// writes the words to consecutive instruction-memory addresses starting at 0.
// Each accepted tuple costs one ACCEPT cycle plus one WRITE cycle.
module instr_word_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_type,
    input  logic [5:0]    in_rs,
    input  logic [5:0]    in_rd,
    input  logic [3:0]    in_funct,
    input  logic [5:0]    in_rt,
    input  logic [8:0]    in_imm9,
    input  logic [14:0]   in_imm15,
    input  logic          in_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [AW:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Highest legal address; a non-last write here ends the session as overflow.
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [AW-1:0] ptr_s;
    logic          full_s;

    // Pack the field tuple; bit 0 carries the instruction type.
    function automatic logic [31:0] encode_word(
        input logic        itype,
        input logic [5:0]  rs,
        input logic [5:0]  rd,
        input logic [3:0]  funct,
        input logic [5:0]  rt,
        input logic [8:0]  imm9,
        input logic [14:0] imm15
    );
        logic [31:0] word;
        if (itype) begin
            word = {imm15, funct, rd, rs, 1'b1};
        end else begin
            word = {imm9, rt, funct, rd, rs, 1'b0};
        end
        return word;
    endfunction

    // The write pointer never wraps, so it is simply the low bits of the count.
    assign ptr_s  = count_q[AW-1:0];
    assign full_s = (ptr_s == LAST_ADDR);

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = S_ACCEPT;
                end else begin
                    state_d = state_q;
                end
            end
            S_ACCEPT: begin
                // Address and word are captured together so they stay stable
                // through the WRITE cycle and are held afterwards.
                if (in_valid) begin
                    wdata_d = encode_word(in_type, in_rs, in_rd, in_funct,
                                          in_rt, in_imm9, in_imm15);
                    last_d  = in_last;
                    addr_d  = ptr_s;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_WRITE: begin
                count_d = count_q + {{AW{1'b0}}, 1'b1};
                // last wins over a full memory, so overflow stays clear then.
                if (last_q) begin
                    state_d = S_DONE;
                end else if (full_s) begin
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode straight from registers; no input-to-output paths.
    always_comb begin
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_ACCEPT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        overflow  = ovf_q;
        count     = count_q;
    end

endmodule

// File: tb/tb_instr_word_loader.sv
// Self-checking bench for instr_word_loader (DEPTH=4): directed cases plus
// randomized load sessions checked against a transaction-level model.
module tb_instr_word_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          in_type;
    logic [5:0]    in_rs;
    logic [5:0]    in_rd;
    logic [3:0]    in_funct;
    logic [5:0]    in_rt;
    logic [8:0]    in_imm9;
    logic [14:0]   in_imm15;
    logic          in_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW:0]   count;

    instr_word_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_rs(in_rs), .in_rd(in_rd), .in_funct(in_funct), .in_rt(in_rt),
        .in_imm9(in_imm9), .in_imm15(in_imm15), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit t;
        int rs;
        int rd;
        int funct;
        int rt;
        int imm9;
        int imm15;
        bit last;
    } tup_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          held_addr = 0;
    logic [31:0] held_data = 32'd0;
    int          cyc = 0;
    int          last_cyc = 0;
    bit          b2b_mode = 1'b0;
    int          sess_idx = 0;
    int          mon_ea;
    logic [31:0] mon_ed;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Word value from field weights: imm9 at 2^23, imm15/rt at 2^17, funct 2^13, rd 2^7, rs 2^1.
    function automatic logic [31:0] model_word(input tup_t x);
        longint w;
        if (!x.t)
            w = longint'(x.imm9) * 64'd8388608 + longint'(x.rt) * 64'd131072 +
                longint'(x.funct) * 64'd8192 + longint'(x.rd) * 64'd128 + longint'(x.rs) * 64'd2;
        else
            w = longint'(x.imm15) * 64'd131072 + longint'(x.funct) * 64'd8192 +
                longint'(x.rd) * 64'd128 + longint'(x.rs) * 64'd2 + 64'd1;
        return w[31:0];
    endfunction

    function automatic tup_t rand_tuple(input bit last);
        tup_t x;
        x.t     = 1'($urandom_range(0, 1));
        x.rs    = int'($urandom_range(0, 63));
        x.rd    = int'($urandom_range(0, 63));
        x.funct = int'($urandom_range(0, 15));
        x.rt    = int'($urandom_range(0, 63));
        x.imm9  = int'($urandom_range(0, 511));
        x.imm15 = int'($urandom_range(0, 32767));
        x.last  = last;
        return x;
    endfunction

    task automatic put_tuple(input tup_t x, input bit v);
        in_valid = v;
        in_type  = x.t;
        in_rs    = 6'(x.rs);
        in_rd    = 6'(x.rd);
        in_funct = 4'(x.funct);
        in_rt    = 6'(x.rt);
        in_imm9  = 9'(x.imm9);
        in_imm15 = 15'(x.imm15);
        in_last  = x.last;
    endtask

    always @(posedge clk) cyc++;

    // Write monitor: every strobe must match the next expected write; otherwise outputs hold.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                chk("ready_in_write", 64'(in_ready), 64'd0);
                chk("busy_in_write", 64'(busy), 64'd1);
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_write", 64'd1, 64'd0);
                end else begin
                    mon_ea = exp_addr_q.pop_front();
                    mon_ed = exp_data_q.pop_front();
                    chk("waddr", 64'(mem_addr), 64'(mon_ea));
                    chk("wdata", 64'(mem_wdata), 64'(mon_ed));
                    if (b2b_mode && mon_ea != 0) chk("b2b_gap", 64'(cyc - last_cyc), 64'd2);
                    last_cyc  = cyc;
                    held_addr = mon_ea;
                    held_data = mon_ed;
                end
            end else begin
                chk("hold_addr", 64'(mem_addr), 64'(held_addr));
                chk("hold_data", 64'(mem_wdata), 64'(held_data));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input tup_t x, input bit exp_acc, input int gap);
        bit ok;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        put_tuple(x, 1'b1);
        if (exp_acc) begin
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                if (in_ready) begin
                    exp_addr_q.push_back(sess_idx);
                    exp_data_q.push_back(model_word(x));
                    sess_idx++;
                    @(posedge clk);
                    @(negedge clk);
                    ok = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
            chk("accept", 64'(ok), 64'd1);
        end else begin
            for (int k = 0; k < 6; k++) begin
                chk("reject_ready", 64'(in_ready), 64'd0);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_session(input bit exp_ovf);
        for (int k = 0; k < 20 && !done; k++) @(negedge clk);
        chk("done", 64'(done), 64'd1);
        chk("overflow", 64'(overflow), 64'(exp_ovf));
        chk("count", 64'(count), 64'(sess_idx));
        chk("busy_done", 64'(busy), 64'd0);
        chk("ready_done", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        chk("done_held", 64'(done), 64'd1);
        chk("writes_left", 64'(exp_addr_q.size()), 64'd0);
        b2b_mode = 1'b0;
    endtask

    // A session: tuples are accepted until the first last or until DEPTH are taken.
    task automatic run_session(input int n, input int last_pos, input bit b2b);
        tup_t x;
        bit   got_last;
        bit   acc;
        got_last = 1'b0;
        pulse_start();
        sess_idx = 0;
        b2b_mode = b2b;
        for (int i = 0; i < n; i++) begin
            x   = rand_tuple(i == last_pos);
            acc = !got_last && (sess_idx < DEPTH);
            if (acc && !b2b && $urandom_range(0, 3) == 0) pulse_start();
            send(x, acc, b2b ? 0 : int'($urandom_range(0, 3)));
            if (acc && x.last) got_last = 1'b1;
        end
        finish_session(!got_last);
    endtask

    task automatic run_one(input tup_t x);
        pulse_start();
        sess_idx = 0;
        send(x, 1'b1, 0);
        finish_session(1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tup_t x;
        bit   ok;
        int   n;
        int   lp;
        rst = 1'b1;
        start = 1'b0;
        x = rand_tuple(1'b0);
        put_tuple(x, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_ready", 64'(in_ready), 64'd0);
        end

        // R-type example word.
        x = '{t: 1'b0, rs: 1, rd: 2, funct: 3, rt: 4, imm9: 5, imm15: 12345, last: 1'b1};
        run_one(x);
        chk("r_word", 64'(mem_wdata), 64'h02886102);
        chk("r_addr", 64'(mem_addr), 64'd0);

        // I-type example word at field extremes.
        x = '{t: 1'b1, rs: 63, rd: 0, funct: 15, rt: 17, imm9: 300, imm15: 32767, last: 1'b1};
        run_one(x);
        chk("i_word", 64'(mem_wdata), 64'hFFFFE07F);

        // Back-to-back, overflow, and last exactly at the final address.
        run_session(3, 2, 1'b1);
        run_session(5, -1, 1'b0);
        run_session(4, 3, 1'b0);

        // Reset landing in the middle of a WRITE cycle.
        pulse_start();
        x = rand_tuple(1'b0);
        put_tuple(x, 1'b1);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (in_ready) ok = 1'b1;
            else @(negedge clk);
        end
        chk("rst_test_accept", 64'(ok), 64'd1);
        @(posedge clk);
        #2;
        chk("pre_rst_we", 64'(mem_we), 64'd1);
        rst = 1'b1;
        held_addr = 0;
        held_data = 32'd0;
        #1;
        chk("mid_rst_we", 64'(mem_we), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_addr", 64'(mem_addr), 64'd0);
        chk("mid_rst_wdata", 64'(mem_wdata), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(busy), 64'd0);
        end
        run_one(rand_tuple(1'b1));

        // Randomized sessions.
        for (int s = 0; s < 40; s++) begin
            n = int'($urandom_range(1, 6));
            if (n >= DEPTH && $urandom_range(0, 1) == 1) lp = -1;
            else lp = int'($urandom_range(0, n - 1));
            run_session(n, lp, 1'b0);
        end

        chk("final_queue", 64'(exp_addr_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
